// File: rtl/multipath_sweep_ctrl_if.sv
// Bus between the path-sweep controller, the 32-path measurement mux and the readout logic.
// The min/spread signals exist only when SWEEP_SPREAD_EN is defined.
interface multipath_sweep_ctrl_if #(
   parameter int SELW = 5,
   parameter int RW   = 32
);
   logic            start;
   logic [RW-1:0]   result;
   logic            fin;
   logic [SELW-1:0] sel;
   logic [SELW-1:0] rd_addr;
   logic [RW-1:0]   rd_data;
   logic            busy;
   logic            done;
   logic            timeout_err;
   logic [RW-1:0]   max_val;
   logic [SELW-1:0] max_path;
`ifdef SWEEP_SPREAD_EN
   logic [RW-1:0]   min_val;
   logic [SELW-1:0] min_path;
   logic [RW-1:0]   spread;
`endif

   // the sweep controller masters the mux select and publishes the results
   modport master (
      input  start, result, fin, rd_addr,
      output sel, rd_data, busy, done, timeout_err, max_val, max_path
`ifdef SWEEP_SPREAD_EN
      , output min_val, min_path, spread
`endif
   );

   modport slave (
      output start, result, fin, rd_addr,
      input  sel, rd_data, busy, done, timeout_err, max_val, max_path
`ifdef SWEEP_SPREAD_EN
      , input min_val, min_path, spread
`endif
   );
endinterface

// File: rtl/multipath_sweep_ctrl.sv
// Automatic sweep over the measurement paths: select, settle, wait for fin, capture, track max.
// Optional min/spread tracking is built when SWEEP_SPREAD_EN is defined.
module multipath_sweep_ctrl #(
   parameter int NPATH   = 32,
   parameter int SELW    = 5,
   parameter int RW      = 32,
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic                  clk250,
   input  logic                  rst_n,
   multipath_sweep_ctrl_if.master bus
);

   localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [SCW-1:0]  SETTLE_LAST = SCW'(SETTLE - 1);
   localparam logic [TCW-1:0]  TO_LAST     = TCW'(TIMEOUT - 1);
   localparam logic [SELW-1:0] LAST_SEL    = SELW'(NPATH - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETTLE   = 3'd1,
      ST_WAIT_FIN = 3'd2,
      ST_CAPTURE  = 3'd3,
      ST_NEXT     = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   state_t          state_r;
   logic [SELW-1:0] sel_r;
   logic            busy_r;
   logic            done_r;
   logic            timeout_err_r;
   logic [RW-1:0]   max_val_r;
   logic [SELW-1:0] max_path_r;
   logic [SCW-1:0]  settle_cnt_r;
   logic [TCW-1:0]  to_cnt_r;
   logic [RW-1:0]   path_buf_r [NPATH];

   logic            timeout_hit_s;
   logic            buf_we_s;
   logic [RW-1:0]   buf_wd_s;

   // buffer write: a captured result, or all-ones marking an abandoned path
   always_comb begin
      timeout_hit_s = 1'b0;
      buf_we_s      = 1'b0;
      buf_wd_s      = '0;
      if (state_r == ST_CAPTURE) begin
         buf_we_s = 1'b1;
         buf_wd_s = bus.result;
      end else if ((state_r == ST_WAIT_FIN) && !bus.fin && (to_cnt_r == TO_LAST)) begin
         timeout_hit_s = 1'b1;
         buf_we_s      = 1'b1;
         buf_wd_s      = '1;
      end else begin
         buf_we_s = 1'b0;
      end
   end

   // result buffer, deliberately not reset so stale entries survive an aborted sweep
   always_ff @(posedge clk250) begin
      if (buf_we_s) begin
         path_buf_r[sel_r] <= buf_wd_s;
      end
   end

   // sweep FSM with registered status outputs
   always_ff @(posedge clk250 or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         sel_r         <= '0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         timeout_err_r <= 1'b0;
         max_val_r     <= '0;
         max_path_r    <= '0;
         settle_cnt_r  <= '0;
         to_cnt_r      <= '0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  sel_r         <= '0;
                  timeout_err_r <= 1'b0;
                  max_val_r     <= '0;
                  max_path_r    <= '0;
                  busy_r        <= 1'b1;
                  settle_cnt_r  <= '0;
                  state_r       <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               // fin/result of the new path are not trusted until the mux has caught up
               if (settle_cnt_r == SETTLE_LAST) begin
                  to_cnt_r <= '0;
                  state_r  <= ST_WAIT_FIN;
               end else begin
                  settle_cnt_r <= settle_cnt_r + SCW'(1);
               end
            end
            ST_WAIT_FIN: begin
               if (bus.fin) begin
                  state_r <= ST_CAPTURE;
               end else if (timeout_hit_s) begin
                  timeout_err_r <= 1'b1;
                  state_r       <= ST_NEXT;
               end else begin
                  to_cnt_r <= to_cnt_r + TCW'(1);
               end
            end
            ST_CAPTURE: begin
               // strict compare: earlier paths keep ties
               if (bus.result > max_val_r) begin
                  max_val_r  <= bus.result;
                  max_path_r <= sel_r;
               end
               state_r <= ST_NEXT;
            end
            ST_NEXT: begin
               if (sel_r == LAST_SEL) begin
                  done_r  <= 1'b1;
                  state_r <= ST_DONE;
               end else begin
                  sel_r        <= sel_r + SELW'(1);
                  settle_cnt_r <= '0;
                  state_r      <= ST_SETTLE;
               end
            end
            ST_DONE: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SWEEP_SPREAD_EN
   logic [RW-1:0]   min_val_r;
   logic [SELW-1:0] min_path_r;
   logic [RW-1:0]   spread_r;

   // min tracking follows the max path; abandoned paths never reach CAPTURE
   always_ff @(posedge clk250 or negedge rst_n) begin
      if (!rst_n) begin
         min_val_r  <= '0;
         min_path_r <= '0;
         spread_r   <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  min_val_r  <= '1;
                  min_path_r <= '0;
                  spread_r   <= '0;
               end
            end
            ST_CAPTURE: begin
               if (bus.result < min_val_r) begin
                  min_val_r  <= bus.result;
                  min_path_r <= sel_r;
               end
            end
            ST_NEXT: begin
               if (sel_r == LAST_SEL) begin
                  spread_r <= max_val_r - min_val_r;
               end
            end
            default: begin
               min_val_r <= min_val_r;
            end
         endcase
      end
   end

   assign bus.min_val  = min_val_r;
   assign bus.min_path = min_path_r;
   assign bus.spread   = spread_r;
`endif

   assign bus.sel         = sel_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.timeout_err = timeout_err_r;
   assign bus.max_val     = max_val_r;
   assign bus.max_path    = max_path_r;
   assign bus.rd_data     = path_buf_r[bus.rd_addr];

endmodule

// File: tb/tb_multipath_sweep_ctrl.sv
// Directed bench for multipath_sweep_ctrl with a behavioural 32-path mux model.
module tb_multipath_sweep_ctrl;

   logic clk250 = 1'b0;
   logic rst_n  = 1'b0;

   multipath_sweep_ctrl_if bus_if ();

   multipath_sweep_ctrl dut (
      .clk250 (clk250),
      .rst_n  (rst_n),
      .bus    (bus_if)
   );

   always #2 clk250 = ~clk250;

   int total = 0;
   int bad   = 0;

   logic [31:0] res_tab [32];
   logic        dead    [32];
   int          fin_dly = 0;
   int          prev_sel = -1;
   int          dly_cnt  = 0;
   int          n;

   // mux model: fin rises fin_dly cycles after a select change, never for dead paths
   initial begin
      bus_if.fin    = 1'b0;
      bus_if.result = 32'd0;
      forever begin
         @(negedge clk250);
         if (int'(bus_if.sel) != prev_sel) begin
            prev_sel = int'(bus_if.sel);
            dly_cnt  = 0;
         end else if (dly_cnt < 10000) begin
            dly_cnt++;
         end
         bus_if.fin    = !dead[bus_if.sel] && (dly_cnt >= fin_dly);
         bus_if.result = res_tab[bus_if.sel];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk250);
      #1;
   endtask

   task automatic pulse_start();
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cnt);
      cnt = 0;
      while (1) begin
         tick();
         cnt++;
         if (bus_if.done === 1'b1) break;
         if (cnt >= budget) begin
            chk("wait_done_bound", {31'd0, bus_if.done}, 32'd1);
            break;
         end
      end
   endtask

   task automatic wait_sel(input logic [4:0] s, input int budget);
      int c;
      c = 0;
      while (bus_if.sel !== s) begin
         tick();
         c++;
         if (c >= budget) begin
            chk("wait_sel_bound", {27'd0, bus_if.sel}, {27'd0, s});
            break;
         end
      end
   endtask

   task automatic check_buf(input int p, input logic [31:0] exp);
      bus_if.rd_addr = 5'(p);
      #1;
      chk($sformatf("buf%0d", p), bus_if.rd_data, exp);
   endtask

   initial begin
      bus_if.start   = 1'b0;
      bus_if.rd_addr = 5'd0;
      for (int i = 0; i < 32; i++) begin
         res_tab[i] = 32'd100 + 32'(i);
         dead[i]    = 1'b0;
      end
      fin_dly = 10;

      // reset, then idle without start
      repeat (3) tick();
      chk("rst_sel", {27'd0, bus_if.sel}, 32'd0);
      chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
      chk("rst_done", {31'd0, bus_if.done}, 32'd0);
      chk("rst_max_val", bus_if.max_val, 32'd0);
      chk("rst_max_path", {27'd0, bus_if.max_path}, 32'd0);
      chk("rst_tmo", {31'd0, bus_if.timeout_err}, 32'd0);
      rst_n = 1'b1;
      repeat (5) tick();
      chk("idle_busy", {31'd0, bus_if.busy}, 32'd0);
      chk("idle_sel", {27'd0, bus_if.sel}, 32'd0);

      // nominal sweep, with a stray start while busy
      pulse_start();
      chk("nom_busy_after_start", {31'd0, bus_if.busy}, 32'd1);
      wait_sel(5'd5, 200);
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      chk("nom_start_ignored_sel", {27'd0, bus_if.sel}, 32'd5);
      chk("nom_start_ignored_busy", {31'd0, bus_if.busy}, 32'd1);
      wait_done(2000, n);
      chk("nom_max_val", bus_if.max_val, 32'd131);
      chk("nom_max_path", {27'd0, bus_if.max_path}, 32'd31);
      chk("nom_tmo", {31'd0, bus_if.timeout_err}, 32'd0);
      tick();
      chk("nom_done_once", {31'd0, bus_if.done}, 32'd0);
      chk("nom_busy_low", {31'd0, bus_if.busy}, 32'd0);
      chk("nom_sel_hold", {27'd0, bus_if.sel}, 32'd31);
      for (int p = 0; p < 32; p++) check_buf(p, 32'd100 + 32'(p));

      // tie at the maximum, fin already high: minimum sweep latency
      for (int i = 0; i < 32; i++) res_tab[i] = 32'd5;
      res_tab[7]  = 32'hFFFF_0000;
      res_tab[20] = 32'hFFFF_0000;
      fin_dly = 0;
      tick();
      pulse_start();
      wait_done(2000, n);
      chk("tie_latency", 32'(n), 32'd224);
      chk("tie_max_val", bus_if.max_val, 32'hFFFF_0000);
      chk("tie_max_path", {27'd0, bus_if.max_path}, 32'd7);
      tick();
      check_buf(20, 32'hFFFF_0000);
      check_buf(3, 32'd5);

      // path 12 never finishes
      for (int i = 0; i < 32; i++) res_tab[i] = 32'd100 + 32'(i);
      res_tab[12] = 32'hFFFF_FFF0;
      dead[12]    = 1'b1;
      fin_dly     = 3;
      pulse_start();
      wait_done(20000, n);
      chk("tmo_err", {31'd0, bus_if.timeout_err}, 32'd1);
      chk("tmo_max_val", bus_if.max_val, 32'd131);
      chk("tmo_max_path", {27'd0, bus_if.max_path}, 32'd31);
      chk("tmo_sel_end", {27'd0, bus_if.sel}, 32'd31);
      tick();
      check_buf(12, 32'hFFFF_FFFF);
      check_buf(13, 32'd113);
      dead[12]    = 1'b0;
      res_tab[12] = 32'd112;

      // asynchronous reset in the middle of a sweep
      fin_dly = 0;
      pulse_start();
      chk("mid_tmo_cleared", {31'd0, bus_if.timeout_err}, 32'd0);
      wait_sel(5'd9, 400);
      chk("mid_max_before", bus_if.max_val, 32'd108);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sel", {27'd0, bus_if.sel}, 32'd0);
      chk("mid_rst_busy", {31'd0, bus_if.busy}, 32'd0);
      chk("mid_rst_max_val", bus_if.max_val, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      pulse_start();
      chk("resweep_sel", {27'd0, bus_if.sel}, 32'd0);
      chk("resweep_busy", {31'd0, bus_if.busy}, 32'd1);
      wait_done(2000, n);
      chk("resweep_latency", 32'(n), 32'd224);
      chk("resweep_max_val", bus_if.max_val, 32'd131);
      tick();
      check_buf(0, 32'd100);
      check_buf(31, 32'd131);

`ifdef SWEEP_SPREAD_EN
      // min and spread tracking
      for (int i = 0; i < 32; i++) res_tab[i] = 32'd50 + 32'(i);
      pulse_start();
      wait_sel(5'd3, 200);
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      chk("spr_start_ignored", {27'd0, bus_if.sel}, 32'd3);
      wait_done(2000, n);
      chk("spr_min_val", bus_if.min_val, 32'd50);
      chk("spr_min_path", {27'd0, bus_if.min_path}, 32'd0);
      chk("spr_spread", bus_if.spread, 32'd31);
      chk("spr_max_val", bus_if.max_val, 32'd81);
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
